// File: rtl/vedic_mul_seq.sv
// Sequential 8x8 unsigned multiplier: four 4x4 partial products pass through one
// shared combinational Vedic multiplier and are shifted into a 16-bit accumulator.

module vedic (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // 2x2 Vedic (urdhva-tiryak) cell: vertical, crosswise, vertical.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic cross0, cross1, carry, top;
    cross0 = x[1] & y[0];
    cross1 = x[0] & y[1];
    carry  = cross0 & cross1;
    top    = x[1] & y[1];
    return {top & carry, top ^ carry, cross0 ^ cross1, x[0] & y[0]};
  endfunction

  logic [3:0] m_ll, m_hl, m_lh, m_hh;

  always_comb begin
    m_ll = vedic2(a[1:0], b[1:0]);
    m_hl = vedic2(a[3:2], b[1:0]);
    m_lh = vedic2(a[1:0], b[3:2]);
    m_hh = vedic2(a[3:2], b[3:2]);
    p    = {4'b0, m_ll} + {2'b0, m_hl, 2'b0} + {2'b0, m_lh, 2'b0} + {m_hh, 4'b0};
  end

endmodule

module vedic_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [3:0]  vm_a, vm_b;
  logic [7:0]  pp;

  // Place the 8-bit partial product at its weight for the given step.
  function automatic logic [15:0] place_pp(input logic [7:0] prod, input logic [1:0] step);
    case (step)
      2'd0:    return {8'b0, prod};
      2'd3:    return {prod, 8'b0};
      default: return {4'b0, prod, 4'b0};
    endcase
  endfunction

  always_comb begin
    case (step_q)
      2'd0:    begin vm_a = a_q[3:0]; vm_b = b_q[3:0]; end
      2'd1:    begin vm_a = a_q[3:0]; vm_b = b_q[7:4]; end
      2'd2:    begin vm_a = a_q[7:4]; vm_b = b_q[3:0]; end
      default: begin vm_a = a_q[7:4]; vm_b = b_q[7:4]; end
    endcase
  end

  vedic u_vedic (
    .a (vm_a),
    .b (vm_b),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'd0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + place_pp(pp, step_q);
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == MUL) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      acc_q       <= 16'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule

// File: doc/vedic_mul_seq.md
# vedic_mul_seq

Multi-cycle 8x8 unsigned multiplier built around one shared instance of the existing 4-bit Vedic multiplier (`vedic`). It splits each 8-bit operand pair into four 4x4 partial products and feeds them through the single multiplier over four consecutive cycles. Each partial product is shifted and accumulated into a 16-bit result. It sits between an upstream operand producer and a downstream consumer, using valid/ready handshakes on both sides.

## Interface
- Parameters: none. Operand width is fixed at 8 and the multiplier slice at 4.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  16  product a*b, unsigned.
- busy  output  1  high in MUL or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - a_r<=a, b_r<=b, acc<=0, step<=0.
    - Next state MUL.
  - MUL: one partial product per cycle, selected by step (2 bits) and driven onto the shared vedic instance.
    - step 0: a_r[3:0]*b_r[3:0], shift 0.
    - step 1: a_r[3:0]*b_r[7:4], shift 4.
    - step 2: a_r[7:4]*b_r[3:0], shift 4.
    - step 3: a_r[7:4]*b_r[7:4], shift 8.
    - Each cycle: acc <= acc + ({8'b0,pp} << shift), computed in 16 bits. The sum never exceeds 0xFE01, so no overflow bit exists.
    - step increments each cycle. At step 3, the next state is DONE.
  - DONE: out_valid=1, result=acc, held stable. On out_valid&&out_ready the next state is IDLE.
- Operands are registered at acceptance. Changes on a/b after acceptance have no effect.
- in_valid outside IDLE is ignored, with no queuing.
- result equals acc at all times. It is don't-care outside DONE but must be deterministic; it reads 0 after reset.
- Multiplier inputs are muxed from a_r/b_r by step only. The multiplier is purely combinational and is sampled in the same cycle.

## Timing
- Reset values after the rst edge:
  - state=IDLE, step=0, acc=0, a_r=b_r=0.
  - in_ready=1, out_valid=0, busy=0, result=0.
- rst has priority over every other input. Asserting rst during MUL or DONE aborts the operation; the next cycle is IDLE with no out_valid pulse.
- Latency: acceptance at edge T. MUL occupies cycles T..T+3 (edges T+1..T+4). out_valid is first high in the cycle after edge T+4, i.e. 4 edges after acceptance.
- Throughput: an output handshake at edge U returns the block to IDLE. The earliest next acceptance is at edge U+1, giving a minimum of 6 edges per operation with out_ready held high.
- Backpressure: DONE holds for any number of cycles while out_ready=0, with result and out_valid constant.
- in_ready and out_valid are never high in the same cycle.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset, then a=0x12, b=0x34 with out_ready=1 -> out_valid 4 edges after acceptance, result=0x03A8, one-cycle out_valid pulse, in_ready back the following cycle.
- a=0xFF, b=0xFF -> result=0xFE01. a=0x0F, b=0xF0 -> 0x0E10. a=0xA5, b=0x00 -> 0x0000. Exercises each shift position.
- out_ready held low for 10 cycles after out_valid -> result and out_valid stable throughout. Handshake on out_ready rise, then IDLE.
- in_valid held high with changing a/b during MUL/DONE -> no second acceptance, result reflects only the first captured operands.
- rst pulsed during MUL step 2 -> next cycle IDLE, out_valid=0, result=0. A subsequent 0x12*0x34 still yields 0x03A8.
- Random back-to-back stream of 1000 operand pairs with random out_ready -> every result matches a*b in order, and no operation is lost or duplicated.
